// File: rtl/motor_timer_pkg.sv
// Shared types and defaults for the motor timer path (timer control FSM and button front ends).
package motor_timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      EXPIRE = 2'd2
   } timer_state_e;

   localparam int SEC_W             = 5;
   localparam int STEP_SEC_DEF      = 5;
   localparam int MAX_SEC_DEF       = 20;
   localparam int TICKS_PER_SEC_DEF = 1000;

   // Preset minus elapsed, clamped at zero; the extra top bit keeps the subtraction from wrapping.
   function automatic logic [SEC_W-1:0] sat_sub(input logic [SEC_W:0] a, input logic [SEC_W-1:0] b);
      logic [SEC_W:0] b_ext;
      b_ext = {1'b0, b};
      if (a > b_ext) begin
         sat_sub = SEC_W'(a - b_ext);
      end else begin
         sat_sub = '0;
      end
   endfunction

endpackage

// File: rtl/timer_mode_ctrl_if.sv
// Timer control bus between the button/motor/counter side and the timer mode controller.
interface timer_mode_ctrl_if;
   import motor_timer_pkg::*;

   logic             i_timer_btn;
   logic             i_motor_on;
   logic [SEC_W-1:0] i_elapsed_sec;
   logic             o_timer_mode;
   logic [SEC_W-1:0] o_time_state;
   logic             o_off_button;
   logic [SEC_W-1:0] o_remaining;
   logic             o_warn;

   modport slave (
      input  i_timer_btn, i_motor_on, i_elapsed_sec,
      output o_timer_mode, o_time_state, o_off_button, o_remaining, o_warn
   );

   modport master (
      output i_timer_btn, i_motor_on, i_elapsed_sec,
      input  o_timer_mode, o_time_state, o_off_button, o_remaining, o_warn
   );

endinterface

// File: rtl/timer_mode_ctrl_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer plus rising-edge detect; a held level yields one pulse.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_rise
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronizer chain followed by one history flop for edge detection.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign o_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: button-driven preset, run enable, expiry off-pulse and remaining-seconds display.
// Optional near-expiry blink on o_warn when TIMER_MODE_CTRL_WARN_EN is defined.
module timer_mode_ctrl
   import motor_timer_pkg::*;
#(
   parameter int STEP_SEC      = STEP_SEC_DEF,
   parameter int MAX_SEC       = MAX_SEC_DEF,
   parameter int OFF_PULSE     = 2,
   parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
   parameter int WARN_SEC      = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   timer_mode_ctrl_if.slave   bus
);

   localparam int SEC_X   = SEC_W + 1;
   localparam int PULSE_W = (OFF_PULSE < 2) ? 1 : $clog2(OFF_PULSE + 1);

   localparam logic [SEC_X-1:0]   STEP_X     = SEC_X'(STEP_SEC);
   localparam logic [SEC_X-1:0]   MAX_X      = SEC_X'(MAX_SEC);
   localparam logic [SEC_W-1:0]   STEP_5     = SEC_W'(STEP_SEC);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(OFF_PULSE);

   timer_state_e       state_q;
   logic               timer_mode_q;
   logic [SEC_W-1:0]   time_state_q;
   logic               off_button_q;
   logic [SEC_W-1:0]   remaining_q;
   logic [PULSE_W-1:0] pulse_cnt_q;

   logic               btn_rise_s;
   logic [SEC_X-1:0]   preset_sum_d;
   logic [SEC_X-1:0]   time_x_s;
   logic [SEC_X-1:0]   elapsed_x_s;

   btn_sync_edge u_btn_sync_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (bus.i_timer_btn),
      .o_rise  (btn_rise_s)
   );

   assign time_x_s     = {1'b0, time_state_q};
   assign elapsed_x_s  = {1'b0, bus.i_elapsed_sec};
   assign preset_sum_d = time_x_s + STEP_X;

   // Timer FSM; o_remaining is computed from the values being loaded so it lines up with o_time_state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         timer_mode_q <= 1'b0;
         time_state_q <= '0;
         off_button_q <= 1'b0;
         remaining_q  <= '0;
         pulse_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               off_button_q <= 1'b0;
               pulse_cnt_q  <= '0;
               if (btn_rise_s && bus.i_motor_on) begin
                  state_q      <= RUN;
                  timer_mode_q <= 1'b1;
                  time_state_q <= STEP_5;
                  remaining_q  <= sat_sub(STEP_X, bus.i_elapsed_sec);
               end else begin
                  timer_mode_q <= 1'b0;
                  time_state_q <= '0;
                  remaining_q  <= '0;
               end
            end
            RUN: begin
               if (!bus.i_motor_on) begin
                  state_q      <= IDLE;
                  timer_mode_q <= 1'b0;
                  time_state_q <= '0;
                  remaining_q  <= '0;
               end else if (elapsed_x_s >= time_x_s) begin
                  state_q      <= EXPIRE;
                  timer_mode_q <= 1'b0;
                  time_state_q <= '0;
                  off_button_q <= 1'b1;
                  pulse_cnt_q  <= PULSE_W'(1);
                  remaining_q  <= '0;
               end else if (btn_rise_s) begin
                  if (preset_sum_d > MAX_X) begin
                     state_q      <= IDLE;
                     timer_mode_q <= 1'b0;
                     time_state_q <= '0;
                     remaining_q  <= '0;
                  end else begin
                     time_state_q <= preset_sum_d[SEC_W-1:0];
                     remaining_q  <= sat_sub(preset_sum_d, bus.i_elapsed_sec);
                  end
               end else begin
                  remaining_q <= sat_sub(time_x_s, bus.i_elapsed_sec);
               end
            end
            EXPIRE: begin
               timer_mode_q <= 1'b0;
               time_state_q <= '0;
               remaining_q  <= '0;
               if (pulse_cnt_q >= PULSE_LAST) begin
                  state_q      <= IDLE;
                  off_button_q <= 1'b0;
                  pulse_cnt_q  <= '0;
               end else begin
                  off_button_q <= 1'b1;
                  pulse_cnt_q  <= pulse_cnt_q + PULSE_W'(1);
               end
            end
            default: begin
               state_q      <= IDLE;
               timer_mode_q <= 1'b0;
               time_state_q <= '0;
               off_button_q <= 1'b0;
               remaining_q  <= '0;
               pulse_cnt_q  <= '0;
            end
         endcase
      end
   end

   assign bus.o_timer_mode = timer_mode_q;
   assign bus.o_time_state = time_state_q;
   assign bus.o_off_button = off_button_q;
   assign bus.o_remaining  = remaining_q;

`ifdef TIMER_MODE_CTRL_WARN_EN
   localparam int HALF_TICKS = TICKS_PER_SEC / 2;
   localparam int BLINK_W    = (HALF_TICKS < 2) ? 1 : $clog2(HALF_TICKS);

   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_TICKS - 1);
   localparam logic [SEC_W-1:0]   WARN_X     = SEC_W'(WARN_SEC);

   logic               window_s;
   logic               warn_q;
   logic               armed_q;
   logic [BLINK_W-1:0] blink_q;

   assign window_s = (state_q == RUN) && (remaining_q != '0) && (remaining_q <= WARN_X);

   // Blink generator: first half-period high on window entry, then toggles every half second.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         warn_q  <= 1'b0;
         armed_q <= 1'b0;
         blink_q <= '0;
      end else if (!window_s) begin
         warn_q  <= 1'b0;
         armed_q <= 1'b0;
         blink_q <= '0;
      end else if (!armed_q) begin
         warn_q  <= 1'b1;
         armed_q <= 1'b1;
         blink_q <= '0;
      end else if (blink_q == BLINK_LAST) begin
         warn_q  <= ~warn_q;
         blink_q <= '0;
      end else begin
         blink_q <= blink_q + BLINK_W'(1);
      end
   end

   assign bus.o_warn = warn_q;
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^{32'(WARN_SEC), 32'(TICKS_PER_SEC)};
   assign bus.o_warn   = 1'b0;
`endif

endmodule

// File: doc/timer_mode_ctrl.md
Name: timer_mode_ctrl

Overview:
- Control FSM directly upstream of the seconds counter.
- Turns timer-button presses into a preset duration (`o_time_state`) and a run enable (`o_timer_mode`) that feed the counter.
- Watches the counter's elapsed-seconds output, detects expiry and issues the motor-off pulse (`o_off_button`), which also clears the counter.
- Provides a saturating remaining-seconds value for the display path.

Parameters:
- STEP_SEC, 5, preset increment per button press (seconds).
- MAX_SEC, 20, largest preset. Must be ≤31 and a multiple of STEP_SEC.
- OFF_PULSE, 2, width of `o_off_button` in i_clk cycles (≥1).
- TICKS_PER_SEC, 1000, i_clk cycles per second (1 kHz system tick).
- WARN_SEC, 3, warning threshold (optional feature only).

Ports:
- i_clk  in  1  1 kHz system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_timer_btn  in  1  raw timer button level, asynchronous to i_clk.
- i_motor_on  in  1  high while the motor FSM is in any running speed.
- i_elapsed_sec  in  5  elapsed seconds from the counter.
- o_timer_mode  out  1  counter run enable.
- o_time_state  out  5  current preset in seconds; 0 means no timer.
- o_off_button  out  1  expiry pulse: clears the counter and requests motor off.
- o_remaining  out  5  seconds remaining, saturating at 0.
- o_warn  out  1  near-expiry blink (optional feature; otherwise tied 0).

Behaviour:
- Reset is i_reset, asynchronous, active-high; clock is i_clk, rising edge.
- On reset: all outputs 0, FSM in IDLE, synchronizer flops 0, pulse counter 0.
- Button path: 2-flop synchronizer, then rising-edge detect giving `btn_rise`, one cycle wide.
  - Latency from button edge to the FSM acting on it is 3 cycles.
  - A held button produces exactly one press.
- FSM states: IDLE, RUN, EXPIRE. All outputs are registered.
- IDLE (`o_timer_mode`=0, `o_time_state`=0):
  - `btn_rise` with `i_motor_on`=1: load `o_time_state`=STEP_SEC, then go to RUN.
  - `btn_rise` with `i_motor_on`=0: ignored.
- RUN (`o_timer_mode`=1). Priority per cycle, highest first:
  1. `i_motor_on`=0: go to IDLE and clear `o_time_state`. No off pulse.
  2. `i_elapsed_sec` ≥ `o_time_state`: go to EXPIRE. Use a ≥ compare so a preset change below the elapsed time expires immediately.
  3. `btn_rise`:
     - If `o_time_state` + STEP_SEC > MAX_SEC: set `o_time_state` to 0 and go to IDLE (cancel, no pulse).
     - Otherwise add STEP_SEC. Elapsed time is not restarted.
- EXPIRE:
  - `o_timer_mode`=0, `o_time_state`=0, `o_off_button`=1 for exactly OFF_PULSE cycles, then go to IDLE.
  - Button presses and `i_motor_on` are ignored while in EXPIRE.
- `o_remaining`:
  - In RUN: registered `o_time_state` − `i_elapsed_sec`, 0 if negative. Computed in 6 bits, no wrap.
  - Otherwise 0.
- Arithmetic: preset addition is done in 6 bits, so no 5-bit wrap-around is possible.
- Reset mid-RUN or mid-EXPIRE: immediate return to IDLE; the off pulse is truncated.

Optional Feature:
- Macro: `TIMER_MODE_CTRL_WARN_EN`.
- Defined:
  - A blink counter of width clog2(TICKS_PER_SEC/2) runs.
  - `o_warn` toggles every TICKS_PER_SEC/2 cycles while in RUN with 0 < `o_remaining` ≤ WARN_SEC.
  - `o_warn` starts at 1 on entry to that window.
  - Outside the window, `o_warn` and the counter are held at 0.
- Not defined: `o_warn` is constant 0, there is no blink counter, and the port list is unchanged.

Decomposition:
- Shared package `motor_timer_pkg` holds:
  - State enum (IDLE=2'd0, RUN=2'd1, EXPIRE=2'd2).
  - SEC_W=5.
  - Default STEP_SEC, MAX_SEC and TICKS_PER_SEC.
- One sub-module: `btn_sync_edge` (2-flop synchronizer plus rising-edge detect, async reset). It is reusable by the speed-button path.

Test Plan:
- Reset and IDLE gating:
  - Assert i_reset for 5 cycles: all outputs 0.
  - With `i_motor_on`=0, press button: `o_time_state` stays 0 and `o_timer_mode` stays 0.
- Preset cycling:
  - With `i_motor_on`=1, press 5 times, 50 cycles apart: `o_time_state` goes 5, 10, 15, 20, then 0 with IDLE.
  - `o_timer_mode` goes 1, 1, 1, 1, 0.
- Expiry:
  - Preset 5, drive `i_elapsed_sec` 0→5: `o_remaining` reads 5, 4, 3, 2, 1, 0.
  - One cycle after elapsed = 5: `o_off_button`=1 for exactly 2 cycles, `o_timer_mode`=0, then IDLE.
- Motor off and collisions:
  - In RUN with preset 10 and elapsed 4, drop `i_motor_on`: IDLE, no `o_off_button`.
  - Repeat with `btn_rise` in the same cycle: motor-off wins.
  - With elapsed ≥ preset and `btn_rise` together: EXPIRE wins.
- Asynchronous reset mid-EXPIRE: assert i_reset in the first pulse cycle; `o_off_button` drops before the next clock edge.
- WARN_EN only:
  - Preset 5, elapsed 2, so remaining 3: `o_warn`=1 for 500 cycles, then 0 for 500 cycles.
  - At remaining 0 or in IDLE: `o_warn`=0.
